// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared state encoding and clock constants for the blink channels
package blink_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    ONESHOT = 2'd2
  } blink_state_t;

  localparam int CLK_HZ       = 25_000_000;
  localparam int MS_TO_CYCLES = CLK_HZ / 1000;

endpackage

// File: rtl/blink_channel.sv
// rtl/blink_channel.sv - one blink channel: IDLE/RUN FSM, half-period counter, HP shadow
// Optional one-shot mode (start input, ONESHOT state) under BLINK_MULTI_ONESHOT_EN.
module blink_channel
  import blink_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef BLINK_MULTI_ONESHOT_EN
  input  logic             start,
`endif
  input  logic [CNT_W-1:0] half_period,
  output logic             led,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  blink_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] hp, hp_n;
  logic             led_n, tick_n;
  logic [CNT_W-1:0] hp_eff;
  logic             term;

  // A latched HP of zero behaves as one, so the terminal compare never underflows.
  assign hp_eff = (hp == '0) ? ONE : hp;
  assign term   = (cnt == hp_eff - ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hp    <= '0;
      led   <= 1'b0;
      tick  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hp    <= hp_n;
      led   <= led_n;
      tick  <= tick_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hp_n    = hp;
    led_n   = led;
    tick_n  = 1'b0;
    case (state)
      IDLE: begin
        led_n = 1'b0;
        cnt_n = '0;
        if (en) begin
          state_n = RUN;
          hp_n    = half_period;
        end
`ifdef BLINK_MULTI_ONESHOT_EN
        else if (start) begin
          state_n = ONESHOT;
          hp_n    = half_period;
          led_n   = 1'b1;
        end
`endif
      end
      RUN: begin
        // Losing enable wins over a coincident toggle: silent return to IDLE.
        if (!en) begin
          state_n = IDLE;
          led_n   = 1'b0;
          cnt_n   = '0;
        end else if (term) begin
          led_n  = ~led;
          tick_n = 1'b1;
          cnt_n  = '0;
          hp_n   = half_period;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
`ifdef BLINK_MULTI_ONESHOT_EN
      ONESHOT: begin
        if (term) begin
          state_n = IDLE;
          led_n   = 1'b0;
          tick_n  = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        led_n   = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/blink_multi.sv
// rtl/blink_multi.sv - array of independent LED blink channels
// Optional per-channel one-shot (start port) under BLINK_MULTI_ONESHOT_EN.
module blink_multi
  import blink_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
`ifdef BLINK_MULTI_ONESHOT_EN
  input  logic [CHANNELS-1:0]       start,
`endif
  input  logic [CHANNELS*CNT_W-1:0] half_period,
  output logic [CHANNELS-1:0]       led,
  output logic [CHANNELS-1:0]       tick
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    blink_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (en[i]),
`ifdef BLINK_MULTI_ONESHOT_EN
      .start      (start[i]),
`endif
      .half_period(half_period[i*CNT_W +: CNT_W]),
      .led        (led[i]),
      .tick       (tick[i])
    );
  end

endmodule

// File: tb/tb_blink_multi.sv
// tb/tb_blink_multi.sv - scoreboard bench for blink_multi against a countdown reference model
module tb_blink_multi;

  localparam int CH = 2;
  localparam int W  = 4;
`ifdef BLINK_MULTI_ONESHOT_EN
  localparam bit ONESHOT_ON = 1'b1;
`else
  localparam bit ONESHOT_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   en;
  logic [CH*W-1:0] half_period;
  logic [CH-1:0]   led;
  logic [CH-1:0]   tick;
`ifdef BLINK_MULTI_ONESHOT_EN
  logic [CH-1:0]   start;
`endif

  blink_multi #(.CHANNELS(CH), .CNT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
`ifdef BLINK_MULTI_ONESHOT_EN
    .start      (start),
`endif
    .half_period(half_period),
    .led        (led),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] led;
    logic [CH-1:0] tick;
  } exp_t;

  exp_t q[$];
  exp_t x;
  int checks = 0;
  int errors = 0;
  int mcyc   = 0;

  // Reference model: mode 0 idle, 1 blinking, 2 one-shot; rem counts cycles left to next event.
  int m_mode[CH];
  int m_rem[CH];
  bit m_led[CH];
  bit m_tick[CH];

  task automatic model_step(input bit r, input logic [CH-1:0] e, input int hp[CH], input logic [CH-1:0] s);
    for (int i = 0; i < CH; i++) begin
      int h;
      h = (hp[i] == 0) ? 1 : hp[i];
      if (r) begin
        m_mode[i] = 0; m_rem[i] = 0; m_led[i] = 0; m_tick[i] = 0;
      end else if (m_mode[i] == 0) begin
        m_tick[i] = 0; m_led[i] = 0;
        if (e[i]) begin
          m_mode[i] = 1; m_rem[i] = h;
        end else if (s[i] && ONESHOT_ON) begin
          m_mode[i] = 2; m_rem[i] = h; m_led[i] = 1;
        end
      end else if (m_mode[i] == 1) begin
        if (!e[i]) begin
          m_mode[i] = 0; m_led[i] = 0; m_tick[i] = 0;
        end else begin
          m_rem[i]--;
          m_tick[i] = (m_rem[i] == 0);
          if (m_rem[i] == 0) begin
            m_led[i] = !m_led[i];
            m_rem[i] = h;
          end
        end
      end else begin
        m_rem[i]--;
        m_tick[i] = (m_rem[i] == 0);
        if (m_rem[i] == 0) begin
          m_mode[i] = 0; m_led[i] = 0;
        end
      end
    end
  endtask

  task automatic cycle(input bit r, input logic [CH-1:0] e, input int h0, input int h1, input logic [CH-1:0] s);
    int   hp[CH];
    exp_t ex;
    @(negedge clk);
    hp[0] = h0; hp[1] = h1;
    rst = r;
    en  = e;
    half_period = {h1[W-1:0], h0[W-1:0]};
`ifdef BLINK_MULTI_ONESHOT_EN
    start = s;
`endif
    model_step(r, e, hp, s);
    for (int i = 0; i < CH; i++) begin
      ex.led[i]  = m_led[i];
      ex.tick[i] = m_tick[i];
    end
    q.push_back(ex);
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        mcyc++;
        checks++;
        if (led !== x.led) begin
          errors++;
          $display("FAIL led cyc=%0d actual=%b required=%b", mcyc, led, x.led);
        end
        checks++;
        if (tick !== x.tick) begin
          errors++;
          $display("FAIL tick cyc=%0d actual=%b required=%b", mcyc, tick, x.tick);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [CH-1:0] e, s;
    int h0, h1;
    bit r;
    rst = 1'b1; en = '0; half_period = '0;
`ifdef BLINK_MULTI_ONESHOT_EN
    start = '0;
`endif
    for (int i = 0; i < CH; i++) begin
      m_mode[i] = 0; m_rem[i] = 0; m_led[i] = 0; m_tick[i] = 0;
    end

    repeat (2) cycle(1, 2'b00, 0, 0, 2'b00);
    repeat (10) cycle(0, 2'b00, 3, 0, 2'b00);

    // Channel 0 at HP=3 until a toggle, then retune to 5 the very next cycle.
    for (int k = 0; k < 40 && !m_tick[0]; k++) cycle(0, 2'b01, 3, 0, 2'b00);
    checks++;
    if (!m_tick[0]) begin
      errors++;
      $display("FAIL wait_toggle0 actual=0 required=1");
    end
    repeat (25) cycle(0, 2'b01, 5, 0, 2'b00);

    // Channel 1 with HP=0 toggles every cycle alongside channel 0.
    repeat (10) cycle(0, 2'b11, 5, 0, 2'b00);

    // Drop en[0] exactly on its toggle cycle.
    for (int k = 0; k < 40 && m_rem[0] != 1; k++) cycle(0, 2'b11, 5, 0, 2'b00);
    checks++;
    if (m_rem[0] != 1) begin
      errors++;
      $display("FAIL wait_term0 actual=%0d required=1", m_rem[0]);
    end
    cycle(0, 2'b10, 5, 0, 2'b00);
    repeat (3) cycle(0, 2'b10, 5, 0, 2'b00);

    // Reset mid-run overrides en and start.
    repeat (7) cycle(0, 2'b11, 2, 1, 2'b00);
    cycle(1, 2'b11, 2, 1, 2'b11);
    repeat (2) cycle(0, 2'b00, 2, 1, 2'b00);

    // One-shot: 4-cycle pulse, a second start mid-pulse, and en priority over start.
    cycle(0, 2'b00, 4, 2, 2'b01);
    cycle(0, 2'b00, 4, 2, 2'b00);
    cycle(0, 2'b00, 4, 2, 2'b01);
    repeat (6) cycle(0, 2'b00, 4, 2, 2'b00);
    cycle(0, 2'b01, 4, 2, 2'b01);
    repeat (6) cycle(0, 2'b01, 4, 2, 2'b00);
    cycle(0, 2'b00, 4, 2, 2'b00);

    // Randomized traffic with persistent en, occasional retunes, starts and resets.
    e = 2'b00; h0 = 3; h1 = 5;
    for (int k = 0; k < 500; k++) begin
      r = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 9) == 0) e[i] = ~e[i];
        s[i] = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 7) == 0) h0 = $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) h1 = $urandom_range(0, 15);
      cycle(r, e, h0, h1, s);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blink_multi.md
BLINK_MULTI -- requirements
Module: blink_multi

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent blink channels, 1..16.
REQ-002 Parameter CNT_W, default 24: width of each per-channel half-period counter; 2^24 cycles = 0.67 s at 25 MHz.
REQ-003 Port clk, input, 1: single system clock, 25 MHz on the Blackice board; all logic on rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port en, input, CHANNELS: per-channel run enable, level-sensitive.
REQ-006 Port half_period, input, CHANNELS*CNT_W: per-channel half period in clk cycles, channel i in bits [i*CNT_W +: CNT_W].
REQ-007 Port led, output, CHANNELS: registered blink outputs.
REQ-008 Port tick, output, CHANNELS: one-cycle registered strobe on every led transition.

Function
REQ-009 Each channel SHALL run a two-state FSM, IDLE and RUN, independent of the other channels.
REQ-010 IDLE: counter=0, led=0, tick=0; go to RUN on the cycle after en[i]=1 is sampled.
REQ-011 On entering RUN, the channel SHALL latch half_period[i] into a shadow register HP and start counting from 0.
REQ-012 RUN: counter increments every cycle; on counter==HP-1 the channel SHALL toggle led, pulse tick for exactly that cycle, reset the counter to 0 and re-latch HP from half_period[i].
REQ-013 Changes to half_period[i] mid-count SHALL NOT affect the current half period; they take effect at the next toggle.
REQ-014 The first led rising edge SHALL occur HP cycles after entering RUN, so the full period is 2*HP cycles.
REQ-015 Latched HP==0 SHALL be treated as HP==1, giving a toggle every cycle.
REQ-016 Deasserting en[i] in RUN SHALL return the channel to IDLE on the next cycle, with led=0 and counter=0, and SHALL NOT pulse tick.
REQ-017 Counter wrap SHALL never occur; the counter is CNT_W bits and the terminal compare bounds it.
REQ-018 A toggle cycle coinciding with en[i] falling SHALL resolve as deassert: go to IDLE, led=0, no tick.

Reset
REQ-019 On rst=1 at a clk edge, all channels SHALL go to IDLE with led=0, tick=0, counter=0, HP=0, and in-progress one-shots cancelled.
REQ-020 rst SHALL override en and start in the same cycle.

Configuration
REQ-021 Macro BLINK_MULTI_ONESHOT_EN SHALL control the one-shot feature.
REQ-022 When defined, it SHALL add input port start[CHANNELS] and state ONESHOT.
REQ-023 A start[i] pulse in IDLE SHALL enter ONESHOT and latch HP.
REQ-024 In ONESHOT, led SHALL be 1 for HP cycles, then 0.
REQ-025 At the end of ONESHOT, tick SHALL pulse once and the channel SHALL return to IDLE.
REQ-026 start[i] SHALL be ignored in RUN or ONESHOT.
REQ-027 en[i]=1 SHALL take priority over start[i] in IDLE.
REQ-028 When the macro is undefined, there SHALL be no start port and no ONESHOT state; behaviour is exactly REQ-009..018.

Structure
REQ-029 Shared package blink_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, ONESHOT=2'd2), CLK_HZ=25_000_000, and a MS_TO_CYCLES helper constant.
REQ-030 Sub-module blink_channel SHALL implement one channel (FSM, counter, HP shadow); blink_multi SHALL instantiate it CHANNELS times via generate.

Verification
REQ-031 Bench parameters CHANNELS=2, CNT_W=4; run 10 cycles after rst with en=0 -> led=00, tick=00 throughout.
REQ-032 en[0]=1 with hp0=3 -> led[0] rises 3 cycles after RUN entry, then toggles every 3 cycles; tick[0] high one cycle per toggle.
REQ-033 hp0 changes 3->5 one cycle after a toggle -> the next toggle is still at 3 cycles, the following ones at 5.
REQ-034 hp1=0 with en[1]=1 -> led[1] toggles every cycle; channel 0 is unaffected.
REQ-035 en[0] drops on its toggle cycle -> led[0]=0 next cycle, no tick pulse; rst mid-RUN -> all outputs 0 next cycle.
REQ-036 With BLINK_MULTI_ONESHOT_EN defined, hp0=4 and a start[0] pulse -> led[0]=1 for exactly 4 cycles, a single tick, then IDLE; a second start during ONESHOT is ignored.
